// File: rtl/fp16_pkg.sv
// Shared FP16 definitions: field widths, special encodings, unpacked operand
// view, operand classes and the subtractor FSM states.
package fp16_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int BIAS   = 15;

  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [15:0] FP16_PINF = 16'h7C00;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W:0]   mant;
  } fp16_unpacked_t;

  typedef enum logic [2:0] {
    FP_ZERO,
    FP_SUB,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp16_class_t;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    ROUND,
    DONE
  } state_t;

  function automatic logic [15:0] fp16_pack(input logic s,
                                            input logic [EXP_W-1:0] e,
                                            input logic [FRAC_W-1:0] f);
    return {s, e, f};
  endfunction

endpackage

// File: rtl/fp16_sub_seq_if.sv
// Operand/result handshake bundle for the sequential FP16 subtractor.
interface fp16_sub_seq_if;
  import fp16_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [EXP_W+FRAC_W:0]     a;
  logic [EXP_W+FRAC_W:0]     b;
  logic                      out_valid;
  logic                      out_ready;
  logic [EXP_W+FRAC_W:0]     diff;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff
  );

endinterface

// File: rtl/fp16_unpack.sv
// Combinational FP16 unpacker: classifies the operand and builds the 11-bit
// mantissa with subnormals mapped onto exponent 1.
module fp16_unpack
  import fp16_pkg::*;
(
  input  logic [15:0]     x,
  output fp16_unpacked_t  u,
  output fp16_class_t     cls
);

  always_comb begin
    u.sign = x[15];
    if (x[14:10] == 5'd0) begin
      u.exp  = 5'd1;
      u.mant = {1'b0, x[9:0]};
      cls    = (x[9:0] == 10'd0) ? FP_ZERO : FP_SUB;
    end else begin
      u.exp  = x[14:10];
      u.mant = {1'b1, x[9:0]};
      if (x[14:10] == 5'h1F) begin
        cls = (x[9:0] == 10'd0) ? FP_INF : FP_NAN;
      end else begin
        cls = FP_NORM;
      end
    end
  end

endmodule

// File: rtl/fp16_sub_seq.sv
// Multi-cycle FP16 subtractor diff = a - b with one-bit-per-cycle normalisation.
// Define FP16_SUB_RNE_EN for guard/round/sticky bits and round-to-nearest-even.
module fp16_sub_seq
  import fp16_pkg::*;
#(
  parameter int MAX_NORM_SHIFTS = 11
)
(
  input  logic          clk,
  input  logic          rst_n,
  fp16_sub_seq_if.slave bus
);

`ifdef FP16_SUB_RNE_EN
  localparam int XB = 3;
`else
  localparam int XB = 0;
`endif
  localparam int MW = FRAC_W + 1 + XB;
  localparam int CW = $clog2(MAX_NORM_SHIFTS + 1);

  state_t            state_reg, state_next;
  logic [15:0]       a_reg, a_next;
  logic [15:0]       b_reg, b_next;
  logic [MW-1:0]     mant_a_reg, mant_a_next;
  logic [MW-1:0]     mant_b_reg, mant_b_next;
  logic [MW-1:0]     mant_reg, mant_next;
  logic [EXP_W-1:0]  exp_reg, exp_next;
  logic              sign_reg, sign_next;
  logic              tie_sign_reg, tie_sign_next;
  logic              special_reg, special_next;
  logic [15:0]       res_reg, res_next;
  logic [15:0]       diff_reg, diff_next;
  logic [CW-1:0]     shift_cnt_reg, shift_cnt_next;

  fp16_unpacked_t    ua, ub;
  fp16_class_t       cls_a, cls_b;
  logic [MW-1:0]     ext_a, ext_b;
  logic [MW:0]       sum;
  logic              rsign;
  logic [15:0]       packed_res;
`ifdef FP16_SUB_RNE_EN
  logic              round_up;
`endif

  // b_reg already carries the flipped sign, so both unpackers see a + (-b).
  fp16_unpack u_unpack_a (.x(a_reg), .u(ua), .cls(cls_a));
  fp16_unpack u_unpack_b (.x(b_reg), .u(ub), .cls(cls_b));

  assign ext_a = MW'(ua.mant) << XB;
  assign ext_b = MW'(ub.mant) << XB;

  function automatic logic [MW-1:0] align_shift(input logic [MW-1:0] m,
                                                input logic [EXP_W-1:0] d);
`ifdef FP16_SUB_RNE_EN
    logic [2*MW-1:0] wide;
    if (d >= 5'(MW)) return {{(MW-1){1'b0}}, |m};
    wide = {m, {MW{1'b0}}} >> d;
    return {wide[2*MW-1:MW+1], wide[MW] | (|wide[MW-1:0])};
`else
    if (d >= 5'd12) return '0;
    return m >> d;
`endif
  endfunction

  always_comb begin
    state_next     = state_reg;
    a_next         = a_reg;
    b_next         = b_reg;
    mant_a_next    = mant_a_reg;
    mant_b_next    = mant_b_reg;
    mant_next      = mant_reg;
    exp_next       = exp_reg;
    sign_next      = sign_reg;
    tie_sign_next  = tie_sign_reg;
    special_next   = special_reg;
    res_next       = res_reg;
    diff_next      = diff_reg;
    shift_cnt_next = shift_cnt_reg;
    sum            = '0;
    rsign          = 1'b0;
    packed_res     = fp16_pack(sign_reg, mant_reg[MW-1] ? exp_reg : 5'd0,
                               mant_reg[MW-2 -: FRAC_W]);
`ifdef FP16_SUB_RNE_EN
    round_up       = 1'b0;
`endif

    unique case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          a_next     = bus.a;
          b_next     = {~bus.b[15], bus.b[14:0]};
          state_next = ALIGN;
        end
      end

      ALIGN: begin
        special_next  = 1'b1;
        tie_sign_next = (ub.exp > ua.exp) ? ub.sign : ua.sign;
        if (cls_a == FP_NAN || cls_b == FP_NAN ||
            (cls_a == FP_INF && cls_b == FP_INF && ua.sign != ub.sign)) begin
          res_next = FP16_QNAN;
        end else if (cls_a == FP_INF) begin
          res_next = {ua.sign, FP16_PINF[14:0]};
        end else if (cls_b == FP_INF) begin
          res_next = {ub.sign, FP16_PINF[14:0]};
        end else begin
          special_next = 1'b0;
          if (ua.exp >= ub.exp) begin
            exp_next    = ua.exp;
            mant_a_next = ext_a;
            mant_b_next = align_shift(ext_b, ua.exp - ub.exp);
          end else begin
            exp_next    = ub.exp;
            mant_a_next = align_shift(ext_a, ub.exp - ua.exp);
            mant_b_next = ext_b;
          end
        end
        // Specials also pass through ADD so every early exit has equal latency.
        state_next = ADD;
      end

      ADD: begin
        shift_cnt_next = '0;
        if (special_reg) begin
          diff_next  = res_reg;
          state_next = DONE;
        end else begin
          if (a_reg[15] == b_reg[15]) begin
            sum   = {1'b0, mant_a_reg} + {1'b0, mant_b_reg};
            rsign = a_reg[15];
          end else if (mant_a_reg > mant_b_reg) begin
            sum   = {1'b0, mant_a_reg} - {1'b0, mant_b_reg};
            rsign = a_reg[15];
          end else if (mant_b_reg > mant_a_reg) begin
            sum   = {1'b0, mant_b_reg} - {1'b0, mant_a_reg};
            rsign = b_reg[15];
          end else begin
            rsign = tie_sign_reg;
          end
          sign_next = rsign;

          if (sum == '0) begin
            diff_next  = (a_reg[15] & b_reg[15]) ? 16'h8000 : 16'h0000;
            state_next = DONE;
          end else if (sum[MW]) begin
            if (exp_reg == 5'd30) begin
              diff_next  = {rsign, FP16_PINF[14:0]};
              state_next = DONE;
            end else begin
`ifdef FP16_SUB_RNE_EN
              mant_next = {sum[MW:2], sum[1] | sum[0]};
`else
              mant_next = sum[MW:1];
`endif
              exp_next   = exp_reg + 5'd1;
              state_next = NORM;
            end
          end else begin
            mant_next  = sum[MW-1:0];
            state_next = NORM;
          end
        end
      end

      NORM: begin
        if (mant_reg[MW-1] || exp_reg <= 5'd1) begin
`ifdef FP16_SUB_RNE_EN
          res_next   = packed_res;
          state_next = ROUND;
`else
          diff_next  = packed_res;
          state_next = DONE;
`endif
        end else begin
          mant_next      = mant_reg << 1;
          exp_next       = exp_reg - 5'd1;
          shift_cnt_next = shift_cnt_reg + CW'(1);
        end
      end

`ifdef FP16_SUB_RNE_EN
      ROUND: begin
        // Incrementing the packed encoding carries frac overflow into exp, up to inf.
        round_up   = mant_reg[2] & (mant_reg[1] | mant_reg[0] | res_reg[0]);
        diff_next  = {res_reg[15], res_reg[14:0] + {14'd0, round_up}};
        state_next = DONE;
      end
`endif

      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      mant_a_reg    <= '0;
      mant_b_reg    <= '0;
      mant_reg      <= '0;
      exp_reg       <= '0;
      sign_reg      <= 1'b0;
      tie_sign_reg  <= 1'b0;
      special_reg   <= 1'b0;
      res_reg       <= '0;
      diff_reg      <= '0;
      shift_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      mant_a_reg    <= mant_a_next;
      mant_b_reg    <= mant_b_next;
      mant_reg      <= mant_next;
      exp_reg       <= exp_next;
      sign_reg      <= sign_next;
      tie_sign_reg  <= tie_sign_next;
      special_reg   <= special_next;
      res_reg       <= res_next;
      diff_reg      <= diff_next;
      shift_cnt_reg <= shift_cnt_next;
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.diff      = diff_reg;

  assert property (@(posedge clk) disable iff (!rst_n)
                   shift_cnt_reg <= CW'(MAX_NORM_SHIFTS));

endmodule

// File: tb/tb_fp16_sub_seq.sv
// Scoreboard bench for fp16_sub_seq: fixed vectors with result and latency
// expectations, output back-pressure and reset during normalisation.
module tb_fp16_sub_seq;

  typedef struct {
    logic [15:0] diff;
    int          lat;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb_q[$];

  fp16_sub_seq_if bus();

  fp16_sub_seq #(.MAX_NORM_SHIFTS(11)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
  endtask

  // Returns just after the accepting edge.
  task automatic send(input logic [15:0] av, input logic [15:0] bv);
    int w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] ed, input int elat, input int hold);
    int   cyc = 0;
    exp_t e;
    sb_q.push_back('{ed, elat});
    send(av, bv);
    while (!bus.out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("out_valid", 32'(bus.out_valid), 32'd1);
    check("sb_depth", 32'(sb_q.size()), 32'd1);
    e = sb_q.pop_front();
    check("diff", 32'(bus.diff), 32'(e.diff));
    check("latency", 32'(cyc), 32'(e.lat));
    $display("op a=%h b=%h diff=%h expected=%h latency=%0d expected_latency=%0d",
             av, bv, bus.diff, e.diff, cyc, e.lat);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_diff", 32'(bus.diff), 32'(e.diff));
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("release_out_valid", 32'(bus.out_valid), 32'd0);
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = 16'h0000;
    bus.b         = 16'h0000;
    bus.out_ready = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_diff", 32'(bus.diff), 32'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //      a         b         diff      lat hold
    run_op(16'h4200, 16'h3C00, 16'h4000, 3,  5);
    run_op(16'h3C00, 16'hBC00, 16'h4000, 3,  0);
    run_op(16'h3C00, 16'h3C00, 16'h0000, 2,  0);
    run_op(16'h8000, 16'h0000, 16'h8000, 2,  0);
    run_op(16'h7BFF, 16'hFBFF, 16'h7C00, 2,  0);
    run_op(16'h7E00, 16'h3C00, 16'h7E00, 2,  0);
    run_op(16'h7C00, 16'h7C00, 16'h7E00, 2,  0);
    run_op(16'h0400, 16'h0200, 16'h0200, 3,  0);
    run_op(16'h4000, 16'h3800, 16'h3E00, 4,  0);
    run_op(16'h3C00, 16'h4000, 16'hBC00, 4,  0);
    run_op(16'h3C01, 16'h3C00, 16'h1400, 13, 0);
    run_op(16'hFC00, 16'h7C00, 16'hFC00, 2,  0);
    run_op(16'h0001, 16'h8001, 16'h0002, 3,  0);

    // Ten left shifts needed; reset lands while the FSM is in NORM.
    sb_q.push_back('{16'h1400, 13});
    send(16'h3C01, 16'h3C00);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("midreset_out_valid", 32'(bus.out_valid), 32'd0);
    check("midreset_in_ready", 32'(bus.in_ready), 32'd1);
    check("midreset_diff", 32'(bus.diff), 32'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h4000, 16'h3800, 16'h3E00, 4, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
